execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have RD1D, RD2D, PCD, ImmExtD, PCPlus4D, inputs, 32 each, decode-stage operands, PC and immediate.
REQ-004 SHALL have Rs1D, Rs2D, RdD, inputs, 5 each, decode-stage register indices.
REQ-005 SHALL have RegWriteD, MemWriteD, BranchD, JumpD, JalrD, ALUSrcD, inputs, 1 each, decode-stage controls.
REQ-006 SHALL have ResultSrcD, input, 2, result select; ALUControlD, input, 3; funct3D, input, 3.
REQ-007 SHALL have FlushE, input, 1, and ForwardAE, ForwardBE, inputs, 2 each, from the hazard unit.
REQ-008 SHALL have ALUResultM, ResultW, inputs, 32 each, forwarding sources.
REQ-009 SHALL have Rs1E, Rs2E, RdE, outputs, 5 each, and ResultSrcE, output, 2, to the hazard unit and memory stage.
REQ-010 SHALL have PCSrcE, output, 1, redirect request; PCTargetE, output, 32, redirect address.
REQ-011 SHALL have SrcAE, SrcBE, WriteDataE, PCPlus4E, outputs, 32 each; ALUControlE, output, 3; RegWriteE, MemWriteE, outputs, 1 each.
REQ-012 SHALL have TakenCount, BubbleCount, outputs, 32 each, event counters.

Function
REQ-013 SHALL capture all D inputs into the E register every cycle; no stall input exists.
REQ-014 SHALL, when FlushE=1 at a rising edge, load a bubble: all controls 0, ResultSrcE=00, Rs1E/Rs2E/RdE=0, data fields 0.
REQ-015 SHALL give FlushE priority over the incoming D values, including when D holds a valid instruction.
REQ-016 SHALL select SrcAE from ForwardAE combinationally: 00 RD1E, 01 ResultW, 10 ALUResultM, 11 RD1E.
REQ-017 SHALL select WriteDataE from ForwardBE with the same encoding applied to RD2E.
REQ-018 SHALL drive SrcBE = ImmExtE when ALUSrcE=1, else WriteDataE.
REQ-019 SHALL evaluate the branch condition on forwarded SrcAE and WriteDataE per funct3E: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge, others false.
REQ-020 SHALL drive PCSrcE = JumpE | (BranchE & condition), combinationally, in the same cycle the instruction is in E.
REQ-021 SHALL drive PCTargetE = (SrcAE + ImmExtE) with bit 0 cleared when JalrE=1, else PCE + ImmExtE; 32-bit modulo.
REQ-022 SHALL increment TakenCount by 1 on each rising edge where PCSrcE=1 and rst=0.
REQ-023 SHALL increment BubbleCount by 1 on each rising edge where FlushE=1 and rst=0.
REQ-024 SHALL wrap both counters from 0xFFFFFFFF to 0.
REQ-025 SHALL count both events in one cycle when PCSrcE and FlushE are both 1.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, load the bubble of REQ-014 and clear both counters; rst overrides FlushE.
REQ-027 SHALL, after reset, drive PCSrcE=0, RegWriteE=0, MemWriteE=0, PCTargetE=ImmExtE-derived 0.
REQ-028 SHALL, on reset mid-branch, suppress the redirect from the next cycle onward.

Structure
REQ-029 SHALL place forward-select encodings, funct3 branch codes and bubble constants in a shared pipeline package.
REQ-030 SHALL implement the condition evaluator as sub-module branch_comparator (a, b, funct3 -> taken).

Verification
REQ-031 SHALL verify forwarding: RD1D=5, ForwardAE=10, ALUResultM=0x20 -> SrcAE=0x20 next cycle; ForwardAE=01, ResultW=7 -> SrcAE=7.
REQ-032 SHALL verify beq taken: RD1=RD2=3, BranchD=1, funct3=000, PCD=0x100, ImmExtD=0x10 -> PCSrcE=1, PCTargetE=0x110, TakenCount+1.
REQ-033 SHALL verify signed vs unsigned: SrcA=0xFFFFFFFF, SrcB=1 -> blt taken, bltu not taken.
REQ-034 SHALL verify jalr: SrcAE=0x203, ImmExtE=0x4, JalrE=1 -> PCTargetE=0x206, PCSrcE=1.
REQ-035 SHALL verify flush: FlushE=1 with RegWriteD=1, RdD=9 -> RegWriteE=0, RdE=0, BubbleCount+1; rst=1 with FlushE=1 -> counters 0.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared pipeline definitions for the execute stage: forwarding selects,
// branch funct3 codes, the D->E pipeline register layout and its bubble value.
package execute_stage_pkg;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_WB     = 2'b01,
        FWD_MEM    = 2'b10,
        FWD_RF_ALT = 2'b11
    } fwd_sel_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_f3_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        jalr;
        logic        alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_control;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm_ext;
        logic [31:0] pc_plus4;
    } ex_reg_t;

    // A bubble is the all-zero record: no writes, no branch, no jump.
    localparam ex_reg_t EX_BUBBLE = '0;

    function automatic logic [31:0] fwd_mux(
        input logic [1:0]  sel,
        input logic [31:0] rf_val,
        input logic [31:0] wb_val,
        input logic [31:0] mem_val
    );
        logic [31:0] res;
        case (sel)
            FWD_WB:  res = wb_val;
            FWD_MEM: res = mem_val;
            default: res = rf_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_comparator.sv
// Branch condition evaluator: compares the forwarded operands according to
// the branch funct3; unsupported codes never take.
module branch_comparator
    import execute_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  funct3,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) <  $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a <  b);
            F3_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: D->E pipeline register with flush, operand forwarding,
// branch/jump resolution and taken/bubble event counters.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] PCD,
    input  logic [31:0] ImmExtD,
    input  logic [31:0] PCPlus4D,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdD,
    input  logic        RegWriteD,
    input  logic        MemWriteD,
    input  logic        BranchD,
    input  logic        JumpD,
    input  logic        JalrD,
    input  logic        ALUSrcD,
    input  logic [1:0]  ResultSrcD,
    input  logic [2:0]  ALUControlD,
    input  logic [2:0]  funct3D,
    input  logic        FlushE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] ResultW,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic [1:0]  ResultSrcE,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic [31:0] SrcAE,
    output logic [31:0] SrcBE,
    output logic [31:0] WriteDataE,
    output logic [31:0] PCPlus4E,
    output logic [2:0]  ALUControlE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic [31:0] TakenCount,
    output logic [31:0] BubbleCount
);

    ex_reg_t     d_in;
    ex_reg_t     ex_q;
    logic        branch_taken;
    logic [31:0] jalr_sum;

    always_comb begin
        d_in             = EX_BUBBLE;
        d_in.reg_write   = RegWriteD;
        d_in.mem_write   = MemWriteD;
        d_in.branch      = BranchD;
        d_in.jump        = JumpD;
        d_in.jalr        = JalrD;
        d_in.alu_src     = ALUSrcD;
        d_in.result_src  = ResultSrcD;
        d_in.alu_control = ALUControlD;
        d_in.funct3      = funct3D;
        d_in.rs1         = Rs1D;
        d_in.rs2         = Rs2D;
        d_in.rd          = RdD;
        d_in.rd1         = RD1D;
        d_in.rd2         = RD2D;
        d_in.pc          = PCD;
        d_in.imm_ext     = ImmExtD;
        d_in.pc_plus4    = PCPlus4D;
    end

    // Reset and flush both squash whatever decode is presenting.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            ex_q <= EX_BUBBLE;
        end else begin
            ex_q <= d_in;
        end
    end

    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign ResultSrcE  = ex_q.result_src;
    assign ALUControlE = ex_q.alu_control;
    assign RegWriteE   = ex_q.reg_write;
    assign MemWriteE   = ex_q.mem_write;
    assign PCPlus4E    = ex_q.pc_plus4;

    assign SrcAE      = fwd_mux(ForwardAE, ex_q.rd1, ResultW, ALUResultM);
    assign WriteDataE = fwd_mux(ForwardBE, ex_q.rd2, ResultW, ALUResultM);
    assign SrcBE      = ex_q.alu_src ? ex_q.imm_ext : WriteDataE;

    branch_comparator u_branch_comparator (
        .a      (SrcAE),
        .b      (WriteDataE),
        .funct3 (ex_q.funct3),
        .taken  (branch_taken)
    );

    assign PCSrcE = ex_q.jump | (ex_q.branch & branch_taken);

    // jalr targets are halfword-aligned by clearing bit 0 of the sum.
    assign jalr_sum  = SrcAE + ex_q.imm_ext;
    assign PCTargetE = ex_q.jalr ? {jalr_sum[31:1], 1'b0} : (ex_q.pc + ex_q.imm_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            TakenCount  <= '0;
            BubbleCount <= '0;
        end else begin
            if (PCSrcE) begin
                TakenCount <= TakenCount + 32'd1;
            end
            if (FlushE) begin
                BubbleCount <= BubbleCount + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand-written
// flush/reset sequences, then randomized traffic against a behavioural model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        RegWriteD, MemWriteD, BranchD, JumpD, JalrD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD, funct3D;
    logic        FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ALUResultM, ResultW;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE;
    logic [31:0] PCTargetE, SrcAE, SrcBE, WriteDataE, PCPlus4E;
    logic [2:0]  ALUControlE;
    logic        RegWriteE, MemWriteE;
    logic [31:0] TakenCount, BubbleCount;

    execute_stage dut (
        .clk(clk), .rst(rst),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD),
        .JumpD(JumpD), .JalrD(JalrD), .ALUSrcD(ALUSrcD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .funct3D(funct3D),
        .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
        .ALUControlE(ALUControlE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .TakenCount(TakenCount), .BubbleCount(BubbleCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1, rd2, pc, imm, pcp4;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw, br, jp, jr, as;
        logic [1:0]  rsrc;
        logic [2:0]  aluc, f3;
    } dinst_t;

    typedef struct {
        dinst_t      d;
        logic        flush;
        logic [1:0]  fa, fb;
        logic [31:0] alum, resw;
        logic        exp_pcsrc;
        logic [31:0] exp_tgt, exp_srca, exp_srcb;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_taken, exp_bubble;
    logic        prev_pcsrc;
    dinst_t      e_model;
    vec_t        vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic dinst_t mkd(input logic [31:0] rd1, rd2, pc, imm,
                                   input logic br, jp, jr, as, input logic [2:0] f3);
        dinst_t d;
        d = '0;
        d.rd1 = rd1; d.rd2 = rd2; d.pc = pc; d.imm = imm; d.pcp4 = pc + 32'd4;
        d.br = br; d.jp = jp; d.jr = jr; d.as = as; d.f3 = f3;
        d.rs1 = 5'd1; d.rs2 = 5'd2; d.rd = 5'd3; d.rw = 1'b1;
        return d;
    endfunction

    function automatic vec_t mkv(input dinst_t d, input logic fl, input logic [1:0] fa, fb,
                                 input logic [31:0] alum, resw,
                                 input logic pcsrc, input logic [31:0] tgt, srca, srcb);
        vec_t v;
        v.d = d; v.flush = fl; v.fa = fa; v.fb = fb; v.alum = alum; v.resw = resw;
        v.exp_pcsrc = pcsrc; v.exp_tgt = tgt; v.exp_srca = srca; v.exp_srcb = srcb;
        return v;
    endfunction

    task automatic drive_d(input dinst_t d, input logic fl);
        RD1D = d.rd1; RD2D = d.rd2; PCD = d.pc; ImmExtD = d.imm; PCPlus4D = d.pcp4;
        Rs1D = d.rs1; Rs2D = d.rs2; RdD = d.rd;
        RegWriteD = d.rw; MemWriteD = d.mw; BranchD = d.br; JumpD = d.jp;
        JalrD = d.jr; ALUSrcD = d.as; ResultSrcD = d.rsrc;
        ALUControlD = d.aluc; funct3D = d.f3; FlushE = fl;
    endtask

    task automatic drive_fwd(input logic [1:0] fa, fb, input logic [31:0] m, w);
        ForwardAE = fa; ForwardBE = fb; ALUResultM = m; ResultW = w;
    endtask

    function automatic logic [31:0] pick_fwd(input logic [1:0] s, input logic [31:0] rf, w, m);
        if (s == 2'b01) return w;
        if (s == 2'b10) return m;
        return rf;
    endfunction

    // Behavioural view of the E-stage outputs from the instruction held in E.
    function automatic logic cond_of(input logic [2:0] f3, input logic [31:0] a, b);
        int signed sa, sb;
        sa = a; sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic model_pcsrc(input dinst_t e);
        logic [31:0] a, wd;
        a  = pick_fwd(ForwardAE, e.rd1, ResultW, ALUResultM);
        wd = pick_fwd(ForwardBE, e.rd2, ResultW, ALUResultM);
        return e.jp || (e.br && cond_of(e.f3, a, wd));
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return $urandom_range(0, 3);
            default: return $urandom;
        endcase
    endfunction

    function automatic dinst_t rnd_inst();
        dinst_t d;
        d.rd1 = rnd_val(); d.rd2 = rnd_val(); d.pc = $urandom; d.imm = rnd_val();
        d.pcp4 = $urandom; d.rs1 = 5'($urandom); d.rs2 = 5'($urandom); d.rd = 5'($urandom);
        d.rw = 1'($urandom); d.mw = 1'($urandom); d.br = 1'($urandom);
        d.jp = ($urandom_range(0, 3) == 0); d.jr = 1'($urandom); d.as = 1'($urandom);
        d.rsrc = 2'($urandom); d.aluc = 3'($urandom); d.f3 = 3'($urandom);
        return d;
    endfunction

    initial begin
        rst = 1'b1;
        drive_d('0, 1'b0);
        drive_fwd(2'b00, 2'b00, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset PCSrcE", {31'd0, PCSrcE}, 32'd0);
        check("reset RegWriteE", {31'd0, RegWriteE}, 32'd0);
        check("reset MemWriteE", {31'd0, MemWriteE}, 32'd0);
        check("reset PCTargetE", PCTargetE, 32'd0);
        check("reset TakenCount", TakenCount, 32'd0);
        check("reset BubbleCount", BubbleCount, 32'd0);
        rst = 1'b0;
        exp_taken = 0; exp_bubble = 0; prev_pcsrc = 1'b0;

        // Directed vectors: D instruction, flush, forwarding inputs seen in E, expected outputs.
        vt.push_back(mkv(mkd(32'd5, 0, 0, 0, 0,0,0,0, 3'd0), 0, 2'b10, 2'b00, 32'h20, 0, 0, 32'h0, 32'h20, 32'h0));
        vt.push_back(mkv(mkd(32'd5, 0, 0, 0, 0,0,0,0, 3'd0), 0, 2'b01, 2'b00, 0, 32'd7, 0, 32'h0, 32'd7, 32'h0));
        vt.push_back(mkv(mkd(3, 3, 32'h100, 32'h10, 1,0,0,0, 3'd0), 0, 0, 0, 0, 0, 1, 32'h110, 32'd3, 32'd3));
        vt.push_back(mkv(mkd(3, 3, 32'h100, 32'h10, 1,0,0,0, 3'd0), 1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0));
        vt.push_back(mkv(mkd(32'hFFFF_FFFF, 1, 32'h200, 8, 1,0,0,0, 3'd4), 0, 0, 0, 0, 0, 1, 32'h208, 32'hFFFF_FFFF, 32'd1));
        vt.push_back(mkv(mkd(32'hFFFF_FFFF, 1, 32'h200, 8, 1,0,0,0, 3'd6), 0, 0, 0, 0, 0, 0, 32'h208, 32'hFFFF_FFFF, 32'd1));
        vt.push_back(mkv(mkd(32'h203, 0, 32'h300, 4, 0,1,1,1, 3'd0), 0, 0, 0, 0, 0, 1, 32'h206, 32'h203, 32'd4));
        vt.push_back(mkv(mkd(9, 9, 32'h40, 8, 1,0,0,0, 3'd1), 0, 0, 0, 0, 0, 0, 32'h48, 32'd9, 32'd9));
        vt.push_back(mkv(mkd(32'h8000_0000, 1, 32'h40, 32'hFFFF_FFFC, 1,0,0,0, 3'd5), 0, 0, 0, 0, 0, 0, 32'h3C, 32'h8000_0000, 32'd1));
        vt.push_back(mkv(mkd(32'h8000_0000, 1, 32'h40, 32'hFFFF_FFFC, 1,0,0,0, 3'd7), 0, 0, 0, 0, 0, 1, 32'h3C, 32'h8000_0000, 32'd1));
        vt.push_back(mkv(mkd(4, 4, 32'h40, 8, 1,0,0,0, 3'd2), 0, 0, 0, 0, 0, 0, 32'h48, 32'd4, 32'd4));
        vt.push_back(mkv(mkd(32'h20, 0, 32'h10, 32'h20, 1,0,0,0, 3'd0), 0, 2'b00, 2'b10, 32'h20, 0, 1, 32'h30, 32'h20, 32'h20));
        vt.push_back(mkv(mkd(32'h11, 32'h22, 0, 0, 0,0,0,0, 3'd0), 0, 2'b11, 2'b11, 32'h99, 32'h77, 0, 32'h0, 32'h11, 32'h22));
        vt.push_back(mkv(mkd(32'h11, 32'h22, 0, 0, 0,0,0,0, 3'd0), 0, 2'b00, 2'b01, 32'h99, 32'h77, 0, 32'h0, 32'h11, 32'h77));

        foreach (vt[i]) begin
            drive_d(vt[i].d, vt[i].flush);
            exp_taken  = exp_taken + {31'd0, prev_pcsrc};
            exp_bubble = exp_bubble + {31'd0, vt[i].flush};
            @(posedge clk);
            #1;
            drive_fwd(vt[i].fa, vt[i].fb, vt[i].alum, vt[i].resw);
            #1;
            check($sformatf("vec%0d PCSrcE", i), {31'd0, PCSrcE}, {31'd0, vt[i].exp_pcsrc});
            check($sformatf("vec%0d PCTargetE", i), PCTargetE, vt[i].exp_tgt);
            check($sformatf("vec%0d SrcAE", i), SrcAE, vt[i].exp_srca);
            check($sformatf("vec%0d SrcBE", i), SrcBE, vt[i].exp_srcb);
            check($sformatf("vec%0d TakenCount", i), TakenCount, exp_taken);
            check($sformatf("vec%0d BubbleCount", i), BubbleCount, exp_bubble);
            prev_pcsrc = vt[i].exp_pcsrc;
        end

        // Flush over a valid register-writing instruction.
        begin
            dinst_t d;
            d = mkd(1, 2, 32'h80, 4, 0, 0, 0, 0, 3'd0);
            d.rw = 1'b1; d.rd = 5'd9;
            drive_d(d, 1'b1);
            exp_taken  = exp_taken + {31'd0, prev_pcsrc};
            exp_bubble = exp_bubble + 32'd1;
            @(posedge clk); #1;
            drive_fwd(0, 0, 0, 0);
            #1;
            check("flush RegWriteE", {31'd0, RegWriteE}, 32'd0);
            check("flush RdE", {27'd0, RdE}, 32'd0);
            check("flush BubbleCount", BubbleCount, exp_bubble);
            check("flush TakenCount", TakenCount, exp_taken);
            prev_pcsrc = 1'b0;
        end

        // Reset while a taken branch sits in E, with FlushE also asserted.
        begin
            dinst_t d;
            d = mkd(3, 3, 32'h100, 32'h10, 1, 0, 0, 0, 3'd0);
            drive_d(d, 1'b0);
            @(posedge clk); #2;
            check("midbranch PCSrcE before rst", {31'd0, PCSrcE}, 32'd1);
            rst = 1'b1;
            drive_d(d, 1'b1);
            @(posedge clk); #2;
            check("rst PCSrcE", {31'd0, PCSrcE}, 32'd0);
            check("rst TakenCount", TakenCount, 32'd0);
            check("rst BubbleCount", BubbleCount, 32'd0);
            check("rst RegWriteE", {31'd0, RegWriteE}, 32'd0);
            rst = 1'b0;
            drive_d(mkd(0, 1, 0, 0, 0, 0, 0, 0, 3'd0), 1'b0);
            @(posedge clk); #2;
            check("post-rst TakenCount", TakenCount, 32'd0);
            exp_taken = 0; exp_bubble = 0;
            e_model = mkd(0, 1, 0, 0, 0, 0, 0, 0, 3'd0);
        end

        // Randomized traffic against the behavioural model.
        for (int n = 0; n < 400; n++) begin
            dinst_t d;
            logic   fl, r;
            logic [31:0] a, wd, exp_tgt;
            d  = rnd_inst();
            fl = ($urandom_range(0, 4) == 0);
            r  = ($urandom_range(0, 29) == 0);
            rst = r;
            drive_d(d, fl);
            if (r) begin
                exp_taken = 0; exp_bubble = 0;
            end else begin
                exp_taken  = exp_taken + {31'd0, model_pcsrc(e_model)};
                exp_bubble = exp_bubble + {31'd0, fl};
            end
            e_model = (r || fl) ? dinst_t'('0) : d;
            @(posedge clk); #1;
            rst = 1'b0;
            drive_fwd(2'($urandom), 2'($urandom), rnd_val(), rnd_val());
            #1;
            a  = pick_fwd(ForwardAE, e_model.rd1, ResultW, ALUResultM);
            wd = pick_fwd(ForwardBE, e_model.rd2, ResultW, ALUResultM);
            exp_tgt = e_model.jr ? ((a + e_model.imm) & ~32'h1) : (e_model.pc + e_model.imm);
            check("rnd SrcAE", SrcAE, a);
            check("rnd WriteDataE", WriteDataE, wd);
            check("rnd SrcBE", SrcBE, e_model.as ? e_model.imm : wd);
            check("rnd PCSrcE", {31'd0, PCSrcE}, {31'd0, model_pcsrc(e_model)});
            check("rnd PCTargetE", PCTargetE, exp_tgt);
            check("rnd RegWriteE", {31'd0, RegWriteE}, {31'd0, e_model.rw});
            check("rnd MemWriteE", {31'd0, MemWriteE}, {31'd0, e_model.mw});
            check("rnd RdE", {27'd0, RdE}, {27'd0, e_model.rd});
            check("rnd Rs1E", {27'd0, Rs1E}, {27'd0, e_model.rs1});
            check("rnd Rs2E", {27'd0, Rs2E}, {27'd0, e_model.rs2});
            check("rnd ResultSrcE", {30'd0, ResultSrcE}, {30'd0, e_model.rsrc});
            check("rnd ALUControlE", {29'd0, ALUControlE}, {29'd0, e_model.aluc});
            check("rnd PCPlus4E", PCPlus4E, e_model.pcp4);
            check("rnd TakenCount", TakenCount, exp_taken);
            check("rnd BubbleCount", BubbleCount, exp_bubble);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
